// File: rtl/link_arb_pkg.sv
// Shared types and sizing helpers for the link arbiter.
package link_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        ACK   = 3'd2,
        REL   = 3'd3,
        DRAIN = 3'd4
    } arb_state_t;

    // Default sizing
    localparam int DEF_NREQ    = 4;
    localparam int DEF_DW      = 8;
    localparam int DEF_TIMEOUT = 16;
    localparam int DEF_CW      = 16;

    // Bits needed to index n items, never less than one
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/link_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr.
module rr_pick
    import link_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
)(
    input  logic [NREQ-1:0]            req,
    input  logic [idx_width(NREQ)-1:0] ptr,
    output logic [idx_width(NREQ)-1:0] winner,
    output logic                       any_req
);

    localparam int GW = idx_width(NREQ);

    // Scan ptr, ptr+1, ... with wraparound; the first set request wins
    always_comb begin
        logic [GW:0]   sum;
        logic [GW-1:0] idx;
        winner  = ptr;
        any_req = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + (GW+1)'(k);
            if (sum >= (GW+1)'(NREQ)) begin
                sum = sum - (GW+1)'(NREQ);
            end
            idx = sum[GW-1:0];
            if (!any_req && req[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/link_arbiter.sv
// Round-robin arbiter sharing one 4-phase req/ack byte link among NREQ
// requesters, with ack timeout recovery and a completed-transfer counter.
module link_arbiter
    import link_arb_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CW      = DEF_CW
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_in,
    input  logic [NREQ*DW-1:0]         data_in,
    output logic [NREQ-1:0]            ack_out,
    output logic                       req_out,
    output logic [DW-1:0]              data_out,
    input  logic                       ack_in,
    output logic [idx_width(NREQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout,
    output logic [CW-1:0]              xfer_cnt
);

    localparam int GW = idx_width(NREQ);
    localparam int TW = idx_width(TIMEOUT);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

    arb_state_t      state, state_nxt;
    logic [GW-1:0]   ptr, ptr_nxt;
    logic [GW-1:0]   winner;
    logic            any_req;
    logic [TW-1:0]   tcnt, tcnt_nxt;
    logic [DW-1:0]   win_data;
    logic [NREQ-1:0] grant_onehot;
    logic [GW-1:0]   grant_succ;
    logic            granted_req;
    logic            tcnt_expired;

    logic [NREQ-1:0] ack_out_nxt;
    logic            req_out_nxt;
    logic [DW-1:0]   data_out_nxt;
    logic [GW-1:0]   grant_id_nxt;
    logic            busy_nxt;
    logic            timeout_nxt;
    logic [CW-1:0]   xfer_cnt_nxt;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req     (req_in),
        .ptr     (ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    assign grant_onehot = NREQ'(1) << grant_id;
    assign grant_succ   = (grant_id == GW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    assign granted_req  = req_in[grant_id];
    assign tcnt_expired = (tcnt == TCNT_LAST);

    // Select the data word of the arbitration winner
    always_comb begin
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == GW'(i)) begin
                win_data = data_in[i*DW +: DW];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic for the 4-phase relay and timeout drain
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = REQ;
            REQ: begin
                if (ack_in) begin
                    state_nxt = ACK;
                end else if (tcnt_expired) begin
                    state_nxt = DRAIN;
                end
            end
            ACK:     if (!granted_req) state_nxt = REL;
            REL:     if (!ack_in) state_nxt = IDLE;
            DRAIN:   if (!ack_in) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs, pointer and wait counter
    always_comb begin
        req_out_nxt  = req_out;
        ack_out_nxt  = ack_out;
        data_out_nxt = data_out;
        grant_id_nxt = grant_id;
        busy_nxt     = busy;
        timeout_nxt  = 1'b0;
        xfer_cnt_nxt = xfer_cnt;
        ptr_nxt      = ptr;
        tcnt_nxt     = tcnt;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_id_nxt = winner;
                    data_out_nxt = win_data;
                    req_out_nxt  = 1'b1;
                    busy_nxt     = 1'b1;
                    tcnt_nxt     = '0;
                end
            end
            REQ: begin
                if (ack_in) begin
                    ack_out_nxt = grant_onehot;
                end else if (tcnt_expired) begin
                    req_out_nxt = 1'b0;
                    timeout_nxt = 1'b1;
                end else begin
                    tcnt_nxt = tcnt + 1'b1;
                end
            end
            ACK: begin
                if (!granted_req) begin
                    req_out_nxt = 1'b0;
                end
            end
            REL: begin
                if (!ack_in) begin
                    ack_out_nxt  = '0;
                    xfer_cnt_nxt = xfer_cnt + 1'b1;
                    ptr_nxt      = grant_succ;
                    busy_nxt     = 1'b0;
                end
            end
            DRAIN: begin
                if (!ack_in) begin
                    ack_out_nxt = '0;
                    ptr_nxt     = grant_succ;
                    busy_nxt    = 1'b0;
                end
            end
            default: begin
                ack_out_nxt = '0;
            end
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            req_out  <= 1'b0;
            ack_out  <= '0;
            data_out <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            xfer_cnt <= '0;
            ptr      <= '0;
            tcnt     <= '0;
        end else begin
            req_out  <= req_out_nxt;
            ack_out  <= ack_out_nxt;
            data_out <= data_out_nxt;
            grant_id <= grant_id_nxt;
            busy     <= busy_nxt;
            timeout  <= timeout_nxt;
            xfer_cnt <= xfer_cnt_nxt;
            ptr      <= ptr_nxt;
            tcnt     <= tcnt_nxt;
        end
    end

endmodule

// File: tb/tb_link_arbiter.sv
// Bench for link_arbiter: reactive requesters and link slave, plus a
// transaction-level round-robin reference.
module tb_link_arbiter;

    localparam int NREQ    = 4;
    localparam int DW      = 8;
    localparam int TIMEOUT = 16;
    localparam int CW      = 16;
    localparam int GW      = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_in;
    logic [NREQ*DW-1:0]   data_in;
    logic [NREQ-1:0]      ack_out;
    logic                 req_out;
    logic [DW-1:0]        data_out;
    logic                 ack_in;
    logic [GW-1:0]        grant_id;
    logic                 busy;
    logic                 timeout;
    logic [CW-1:0]        xfer_cnt;

    link_arbiter #(
        .NREQ    (NREQ),
        .DW      (DW),
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_in   (req_in),
        .data_in  (data_in),
        .ack_out  (ack_out),
        .req_out  (req_out),
        .data_out (data_out),
        .ack_in   (ack_in),
        .grant_id (grant_id),
        .busy     (busy),
        .timeout  (timeout),
        .xfer_cnt (xfer_cnt)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    // Environment knobs and state
    int           budget[NREQ];
    logic [DW-1:0] fixed_data[NREQ];
    int           raise_cyc[NREQ];
    bit           rand_data, rand_delay, slave_never;
    int           ack_delay, ack_wait;

    // Reference model state
    int           ptr_model, xfer_model, cur_g, rq_len, to_cnt, last_grant_cyc;
    bit           busy_q, req_out_q, cur_timed;
    logic [DW-1:0] cur_data;
    logic [NREQ-1:0] ack_seen;
    int           grant_log[$];

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int rrRef(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int logAt(input int k);
        if (k < grant_log.size()) return grant_log[k];
        return -1;
    endfunction

    function automatic bit allDone();
        int s = 0;
        foreach (budget[i]) s += budget[i];
        return (s == 0) && (req_in == '0) && !busy && (ack_out == '0) && !ack_in;
    endfunction

    task automatic resetModel();
        ptr_model  = 0;
        xfer_model = 0;
        busy_q     = 1'b0;
        req_out_q  = 1'b0;
        rq_len     = 0;
        to_cnt     = 0;
        cur_g      = 0;
        cur_data   = '0;
        cur_timed  = 1'b0;
    endtask

    // Compare DUT behaviour against the transaction-level expectations
    task automatic observe(input logic [NREQ-1:0] r_e, input logic [NREQ*DW-1:0] d_e);
        int exp_g;
        ack_seen |= ack_out;
        if (busy && !busy_q) begin
            exp_g = rrRef(r_e, ptr_model);
            checkOutput("grant_id", grant_id, exp_g);
            cur_g = (exp_g < 0) ? 0 : exp_g;
            cur_data = d_e[cur_g*DW +: DW];
            checkOutput("data_capture", data_out, cur_data);
            cur_timed      = slave_never;
            rq_len         = 0;
            to_cnt         = 0;
            last_grant_cyc = cyc;
            grant_log.push_back(int'(grant_id));
        end
        if (busy) begin
            checkOutput("data_hold", data_out, cur_data);
            checkOutput("ack_only_granted", ack_out & ~(NREQ'(1) << cur_g), 0);
        end else begin
            checkOutput("ack_idle", ack_out, 0);
        end
        if (req_out) rq_len++;
        if (timeout) to_cnt++;
        if (!req_out && req_out_q && cur_timed) begin
            checkOutput("req_len", rq_len, TIMEOUT);
        end
        if (!busy && busy_q) begin
            if (!cur_timed) xfer_model++;
            ptr_model = (cur_g + 1) % NREQ;
            checkOutput("xfer_cnt", xfer_cnt, xfer_model);
            checkOutput("timeout_pulses", to_cnt, cur_timed ? 1 : 0);
        end
        busy_q    = busy;
        req_out_q = req_out;
    endtask

    // Reactive requesters and link slave
    task automatic applyStimulus();
        if (slave_never) begin
            ack_in = 1'b0;
        end else if (req_out && !ack_in) begin
            if (ack_wait >= ack_delay) begin
                ack_in   = 1'b1;
                ack_wait = 0;
                if (rand_delay) ack_delay = $urandom_range(0, 3);
            end else begin
                ack_wait++;
            end
        end else if (!req_out && ack_in) begin
            ack_in = 1'b0;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req_in[i] && ack_out[i]) begin
                req_in[i] = 1'b0;
            end else if (!req_in[i] && !ack_out[i] && budget[i] > 0) begin
                req_in[i] = 1'b1;
                budget[i]--;
                raise_cyc[i] = cyc;
                data_in[i*DW +: DW] = rand_data ? DW'($urandom) : fixed_data[i];
            end
        end
        if (rand_data && busy && $urandom_range(0, 3) == 0) begin
            data_in[cur_g*DW +: DW] = DW'($urandom);
        end
    endtask

    task automatic tick();
        logic [NREQ-1:0]    r_e;
        logic [NREQ*DW-1:0] d_e;
        logic               rst_e;
        r_e   = req_in;
        d_e   = data_in;
        rst_e = rst;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_e) resetModel();
        else observe(r_e, d_e);
        applyStimulus();
    endtask

    task automatic applyReset();
        rst         = 1'b1;
        req_in      = '0;
        ack_in      = 1'b0;
        data_in     = '0;
        ack_wait    = 0;
        slave_never = 1'b0;
        foreach (budget[i]) budget[i] = 0;
        tick();
        tick();
        rst = 1'b0;
        grant_log.delete();
        ack_seen = '0;
    endtask

    task automatic waitDone(input int maxc, input string tag);
        int n = 0;
        while (!allDone() && n < maxc) begin
            tick();
            n++;
        end
        checkOutput({tag, "_complete"}, allDone(), 1);
    endtask

    initial begin
        int n;
        int total;
        int exp2[5];
        int exp3[4];
        exp2 = '{0, 1, 2, 3, 0};
        exp3 = '{1, 3, 1, 3};
        rand_data  = 1'b0;
        rand_delay = 1'b0;
        ack_delay  = 0;
        foreach (fixed_data[i]) fixed_data[i] = DW'(8'h10 + i);
        foreach (raise_cyc[i]) raise_cyc[i] = 0;
        last_grant_cyc = 0;
        resetModel();

        // Single requester 2, slave answers one cycle after req_out
        applyReset();
        checkOutput("rst_req_out", req_out, 0);
        checkOutput("rst_ack_out", ack_out, 0);
        checkOutput("rst_data_out", data_out, 0);
        checkOutput("rst_grant_id", grant_id, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_timeout", timeout, 0);
        checkOutput("rst_xfer_cnt", xfer_cnt, 0);
        fixed_data[2] = 8'hA5;
        ack_delay = 1;
        budget[2] = 1;
        waitDone(60, "t1");
        checkOutput("t1_grant", logAt(0), 2);
        checkOutput("t1_latency", last_grant_cyc - raise_cyc[2], 1);
        checkOutput("t1_ack_seen", ack_seen, 4'b0100);
        checkOutput("t1_xfer", xfer_cnt, 1);
        checkOutput("t1_data", data_out, 8'hA5);

        // All four request together; requester 0 comes back once
        applyReset();
        ack_delay = 0;
        rand_data = 1'b1;
        budget[0] = 2; budget[1] = 1; budget[2] = 1; budget[3] = 1;
        waitDone(200, "t2");
        for (int k = 0; k < 5; k++) checkOutput($sformatf("t2_grant%0d", k), logAt(k), exp2[k]);
        checkOutput("t2_count", grant_log.size(), 5);
        checkOutput("t2_xfer", xfer_cnt, 5);

        // Requesters 1 and 3 keep asking
        applyReset();
        budget[1] = 2; budget[3] = 2;
        waitDone(200, "t3");
        for (int k = 0; k < 4; k++) checkOutput($sformatf("t3_grant%0d", k), logAt(k), exp3[k]);
        for (int k = 0; k < 3; k++) checkOutput($sformatf("t3_repeat%0d", k), logAt(k) == logAt(k + 1), 0);

        // Slave never answers the first transfer
        applyReset();
        rand_data   = 1'b0;
        slave_never = 1'b1;
        budget[0] = 1; budget[1] = 1;
        n = 0;
        while (!(grant_log.size() >= 1 && !busy) && n < 80) begin
            tick();
            n++;
        end
        checkOutput("t4_drained", (grant_log.size() >= 1) && !busy, 1);
        checkOutput("t4_xfer_after_to", xfer_cnt, 0);
        checkOutput("t4_to_pulse", to_cnt, 1);
        checkOutput("t4_req_len", rq_len, TIMEOUT);
        slave_never = 1'b0;
        waitDone(100, "t4");
        checkOutput("t4_first", logAt(0), 0);
        checkOutput("t4_next", logAt(1), 1);
        checkOutput("t4_retry", logAt(2), 0);
        checkOutput("t4_xfer", xfer_cnt, 2);

        // Reset while the link is in the acknowledge phase
        applyReset();
        ack_delay = 0;
        budget[1] = 1;
        waitDone(60, "t5a");
        ack_delay = 2;
        budget[3] = 1;
        n = 0;
        while (!ack_out[3] && n < 60) begin
            tick();
            n++;
        end
        checkOutput("t5_reach_ack", ack_out[3], 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t5_req_out", req_out, 0);
        checkOutput("t5_ack_out", ack_out, 0);
        checkOutput("t5_busy", busy, 0);
        checkOutput("t5_xfer", xfer_cnt, 0);
        grant_log.delete();
        budget[1] = 1; budget[3] = 1;
        waitDone(80, "t5b");
        checkOutput("t5_first_after_rst", logAt(0), 1);

        // Requester 1 changes its data while waiting for the slave
        applyReset();
        fixed_data[1] = 8'h3C;
        ack_delay = 3;
        budget[1] = 1;
        n = 0;
        while (!req_out && n < 20) begin
            tick();
            n++;
        end
        checkOutput("t6_in_req", req_out, 1);
        data_in[DW +: DW] = 8'hFF;
        tick();
        checkOutput("t6_data_mid", data_out, 8'h3C);
        waitDone(60, "t6");
        checkOutput("t6_data_end", data_out, 8'h3C);

        // Random traffic with random slave latency
        applyReset();
        rand_data  = 1'b1;
        rand_delay = 1'b1;
        ack_delay  = $urandom_range(0, 3);
        total = 0;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                budget[i] = $urandom_range(0, 4);
                total += budget[i];
            end
            waitDone(3000, $sformatf("rand%0d", r));
            checkOutput($sformatf("rand%0d_xfer", r), xfer_cnt, total);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/link_arbiter.md
Name: link_arbiter

Overview:
Round-robin arbiter that shares one 4-phase req/ack byte link (slave side) between NREQ master-side requesters. It grants one requester at a time and holds the grant through the full 4-phase handshake. It relays req, data and ack between the granted requester and the link, and releases the grant only after the link returns to idle. A timeout recovers from a slave that never acknowledges.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 8, data width per transfer
TIMEOUT, 16, max cycles req_out waits for ack_in (>=2)
CW, 16, width of completed-transfer counter

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
req_in  in  NREQ  per-requester 4-phase request
data_in  in  NREQ*DW  requester i data at bits [i*DW +: DW]
ack_out  out  NREQ  per-requester acknowledge
req_out  out  1  request to link slave
data_out  out  DW  data to link slave
ack_in  in  1  acknowledge from link slave
grant_id  out  clog2(NREQ)  index of current/last granted requester
busy  out  1  grant held (state != IDLE)
timeout  out  1  one-cycle pulse on ack timeout
xfer_cnt  out  CW  completed handshakes, wraps at 2^CW

Behaviour:
- All outputs are registered. Reset values: req_out=0, ack_out=0, data_out=0, grant_id=0, busy=0, timeout=0, xfer_cnt=0. Internal: ptr=0, state=IDLE, tcnt=0.
- Round-robin pick: winner is the first i with req_in[i]=1, scanning ptr, ptr+1, ... mod NREQ.
- IDLE: if any req_in=1 at edge k:
  - grant_id<=winner, data_out<=data_in[winner] (captured, held stable for the whole transfer), req_out<=1, busy<=1, tcnt<=0, state->REQ.
  - req_out is visible from cycle k+1.
- REQ: wait for ack_in.
  - ack_in=1 at the edge: ack_out[g]<=1, state->ACK.
  - Otherwise tcnt++. If tcnt==TIMEOUT-1 and ack_in=0: req_out<=0, timeout<=1 for one cycle, state->DRAIN. req_out is therefore high for exactly TIMEOUT cycles.
  - ack_in=1 on the same edge as expiry: the ack wins and no timeout is raised.
- ACK: req_out=1, ack_out[g]=1. When req_in[g] is sampled 0: req_out<=0, state->REL.
- REL: ack_out[g] stays 1. When ack_in is sampled 0:
  - ack_out[g]<=0, xfer_cnt++, ptr<=(g+1) mod NREQ, busy<=0, state->IDLE.
- DRAIN (timeout path): req_out=0, ack_out all 0. When ack_in is sampled 0:
  - ptr<=(g+1) mod NREQ, busy<=0, state->IDLE.
  - xfer_cnt is unchanged. The requester keeps req_in high and re-arbitrates fairly.
- Rules:
  - Only ack_out[grant_id] may ever be 1.
  - Changes to data_in or to non-granted req_in during a transfer have no effect.
  - A new grant starts no earlier than the cycle after returning to IDLE: one idle arbitration cycle between transfers.
- Minimum transfer with zero-wait responders: 5 cycles from req_in rise to IDLE.
- Protocol violations:
  - req_in[g] dropping while in REQ is ignored; the handshake completes or times out.
  - Requesters must not re-raise req_in before their ack_out falls.
- rst mid-transfer: all state and outputs return to reset values on the next edge. The link slave is reset by the same rst.
- grant_id holds its last value while IDLE.

Decomposition:
- Package link_arb_pkg holds:
  - state encoding (IDLE, REQ, ACK, REL, DRAIN)
  - default widths
  - the clog2 helper constant
- One sub-module, rr_pick: combinational; inputs req vector and ptr, outputs winner index and any_req.
- FSM, timeout counter and xfer_cnt stay in link_arbiter.

Test Plan:
1. Only req_in[2] rises with data 0xA5; slave acks 1 cycle after req_out.
   -> grant_id=2, req_out rises the next cycle, data_out=0xA5 held through the transfer, ack_out[2] mirrors the handshake, ack_out[0,1,3]=0, xfer_cnt 0->1.
2. req_in[0..3] all rise together after reset; each re-requests only after its ack_out falls.
   -> grant order 0,1,2,3,0, and xfer_cnt=5 after five transfers.
3. req_in[1] and req_in[3] held continuously.
   -> grants alternate 1,3,1,3; neither is granted twice in a row.
4. TIMEOUT=16, slave never acks.
   -> req_out high exactly 16 cycles, timeout pulses for 1 cycle, xfer_cnt unchanged, the next pending requester is granted after DRAIN.
5. rst asserted for 1 cycle while in ACK.
   -> req_out, ack_out, busy and xfer_cnt are 0 the next cycle; the next arbitration starts from ptr=0.
6. data_in[1] changes 0x3C->0xFF while requester 1 is in REQ.
   -> data_out stays 0x3C until the transfer completes.
